// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake: one operation in flight, single-cycle
// logic ops, bit-serial shifts and a shift-add multiply, with a registered result.
module alu_seq #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      alu_control,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd_write_val,
    output logic            illegal_op,
    output logic            busy
);

    localparam int CNT_W = SHAMT_W + 1;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_XOR  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_SLL  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_SLT  = 5'd8;
    localparam logic [4:0] OP_SLTU = 5'd9;
    localparam logic [4:0] OP_MUL  = 5'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         op_q, op_d;
    logic [XLEN-1:0]    acc_q, acc_d;
    logic [XLEN-1:0]    mcand_q, mcand_d;
    logic [XLEN-1:0]    mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    res_q, res_d;
    logic               illegal_q, illegal_d;

    logic [XLEN-1:0]    alu_res;
    logic               alu_ill;
    logic [XLEN-1:0]    step_val;
    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;

    assign shamt    = rs2_val[SHAMT_W-1:0];
    assign is_shift = (alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                      (alu_control == OP_SRA);

    // Shifts produce rs1 here because this path is only taken for shamt == 0.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (alu_control)
            OP_ADD:  alu_res = rs1_val + rs2_val;
            OP_SUB:  alu_res = rs1_val - rs2_val;
            OP_XOR:  alu_res = rs1_val ^ rs2_val;
            OP_OR:   alu_res = rs1_val | rs2_val;
            OP_AND:  alu_res = rs1_val & rs2_val;
            OP_SLL, OP_SRL, OP_SRA: alu_res = rs1_val;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(rs2_val)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, rs1_val < rs2_val};
            OP_MUL:  alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        step_val = acc_q;
        case (op_q)
            OP_SLL:  step_val = acc_q << 1;
            OP_SRL:  step_val = acc_q >> 1;
            OP_SRA:  step_val = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
            OP_MUL:  step_val = acc_q + (mplier_q[0] ? mcand_q : '0);
            default: step_val = acc_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d = alu_control;
                    if (is_shift && (shamt != '0)) begin
                        acc_d   = rs1_val;
                        cnt_d   = {1'b0, shamt};
                        state_d = ST_BUSY;
                    end else if (alu_control == OP_MUL) begin
                        acc_d    = '0;
                        mcand_d  = rs1_val;
                        mplier_d = rs2_val;
                        cnt_d    = CNT_W'(XLEN);
                        state_d  = ST_BUSY;
                    end else begin
                        res_d     = alu_res;
                        illegal_d = alu_ill;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                // The multiplier operand registers only matter for MUL; shifting them is harmless otherwise.
                acc_d    = step_val;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    res_d     = step_val;
                    illegal_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign out_valid    = (state_q == ST_DONE);
    assign rd_write_val = res_q;
    assign illegal_op   = illegal_q;

endmodule
